// File: rtl/segment_led_pkg.sv
// Glyph table, segment bit positions and fixed patterns for the two-digit display driver.
package segment_led_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;
    localparam int SEG_P = 7;
    localparam int SEG_S = 8;

    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;

    // Logical polarity: digit disabled with all segments dark / digit enabled but blank.
    localparam logic [8:0] PAT_DISABLED = 9'h100;
    localparam logic [8:0] PAT_BLANK    = 9'h000;

    localparam logic [7:0] INVERT_MASK = 8'hFF;

endpackage

// File: rtl/seg7_glyph.sv
// Combinational decimal digit to seven-segment glyph lookup; 0 cycles latency, no backpressure.
module seg7_glyph
    import segment_led_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = 7'h00;
        case (digit)
            4'd0:    glyph = GLYPH_0;
            4'd1:    glyph = GLYPH_1;
            4'd2:    glyph = GLYPH_2;
            4'd3:    glyph = GLYPH_3;
            4'd4:    glyph = GLYPH_4;
            4'd5:    glyph = GLYPH_5;
            4'd6:    glyph = GLYPH_6;
            4'd7:    glyph = GLYPH_7;
            4'd8:    glyph = GLYPH_8;
            4'd9:    glyph = GLYPH_9;
            default: glyph = 7'h00;
        endcase
    end

endmodule

// File: rtl/segment_led.sv
// Two-digit seven-segment driver for a 0-15 count; outputs registered, 1 cycle latency.
// No handshake: heart_cnt is sampled every cycle.
module segment_led
    import segment_led_pkg::*;
#(
    parameter bit ACTIVE_LOW         = 1'b0,
    parameter bit BLANK_LEADING_ZERO = 1'b0
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] heart_cnt,
    output logic [8:0] Segment_led_1,
    output logic [8:0] Segment_led_2
);

    localparam logic [7:0] POL_MASK = ACTIVE_LOW ? INVERT_MASK : 8'h00;

    logic       tens;
    logic [3:0] units;
    logic [6:0] tens_glyph;
    logic [6:0] units_glyph;
    logic [8:0] tens_pat;
    logic [8:0] units_pat;
    logic [8:0] tens_out;
    logic [8:0] units_out;
    logic [8:0] reset_out;

    // Range is only 0-15, so a single compare-and-subtract replaces a divide.
    assign tens  = (heart_cnt >= 4'd10);
    assign units = tens ? (heart_cnt - 4'd10) : heart_cnt;

    seg7_glyph u_tens_glyph (
        .digit ({3'b000, tens}),
        .glyph (tens_glyph)
    );

    seg7_glyph u_units_glyph (
        .digit (units),
        .glyph (units_glyph)
    );

    always_comb begin
        tens_pat  = {1'b0, 1'b0, tens_glyph};
        units_pat = {1'b0, 1'b0, units_glyph};
        if (BLANK_LEADING_ZERO && !tens) begin
            tens_pat = PAT_BLANK;
        end
    end

    // Polarity applies to P and segments only; the digit select keeps its sense.
    assign tens_out  = {tens_pat[SEG_S],     tens_pat[SEG_P:SEG_A]     ^ POL_MASK};
    assign units_out = {units_pat[SEG_S],    units_pat[SEG_P:SEG_A]    ^ POL_MASK};
    assign reset_out = {PAT_DISABLED[SEG_S], PAT_DISABLED[SEG_P:SEG_A] ^ POL_MASK};

    always_ff @(posedge clk) begin
        if (rst) begin
            Segment_led_1 <= reset_out;
            Segment_led_2 <= reset_out;
        end else begin
            Segment_led_1 <= tens_out;
            Segment_led_2 <= units_out;
        end
    end

endmodule

// File: tb/tb_segment_led.sv
// Bench for segment_led: default, blanking and active-low instances share one stimulus stream.
module tb_segment_led;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] heart_cnt = 4'd0;

    logic [8:0] d_tens, d_units;
    logic [8:0] b_tens, b_units;
    logic [8:0] a_tens, a_units;

    int checks = 0;
    int passes = 0;

    logic [6:0] glyph_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                   7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    always #5 clk = ~clk;

    segment_led #(.ACTIVE_LOW(1'b0), .BLANK_LEADING_ZERO(1'b0)) u_dut_def (
        .clk           (clk),
        .rst           (rst),
        .heart_cnt     (heart_cnt),
        .Segment_led_1 (d_tens),
        .Segment_led_2 (d_units)
    );

    segment_led #(.ACTIVE_LOW(1'b0), .BLANK_LEADING_ZERO(1'b1)) u_dut_blank (
        .clk           (clk),
        .rst           (rst),
        .heart_cnt     (heart_cnt),
        .Segment_led_1 (b_tens),
        .Segment_led_2 (b_units)
    );

    segment_led #(.ACTIVE_LOW(1'b1), .BLANK_LEADING_ZERO(1'b0)) u_dut_al (
        .clk           (clk),
        .rst           (rst),
        .heart_cnt     (heart_cnt),
        .Segment_led_1 (a_tens),
        .Segment_led_2 (a_units)
    );

    // Reference: decimal digits via plain arithmetic, then blank/polarity rules.
    function automatic logic [8:0] model(int v, bit is_tens, bit blank, bit al, bit r);
        logic [8:0] p;
        int d;
        if (r) begin
            p = 9'h100;
        end else begin
            d = is_tens ? (v / 10) : (v % 10);
            if (is_tens && blank && v < 10) p = 9'h000;
            else                            p = {2'b00, glyph_tab[d]};
        end
        if (al) p[7:0] = ~p[7:0];
        return p;
    endfunction

    task automatic check(string tag, logic [8:0] obs, logic [8:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Apply one input set for one rising edge, then sample 1 time unit later.
    task automatic tick(logic [3:0] v, logic r);
        @(negedge clk);
        heart_cnt = v;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(string tag);
        int v;
        v = int'(heart_cnt);
        check({tag, "/def_t"},   d_tens,  model(v, 1'b1, 1'b0, 1'b0, rst));
        check({tag, "/def_u"},   d_units, model(v, 1'b0, 1'b0, 1'b0, rst));
        check({tag, "/blank_t"}, b_tens,  model(v, 1'b1, 1'b1, 1'b0, rst));
        check({tag, "/blank_u"}, b_units, model(v, 1'b0, 1'b1, 1'b0, rst));
        check({tag, "/al_t"},    a_tens,  model(v, 1'b1, 1'b0, 1'b1, rst));
        check({tag, "/al_u"},    a_units, model(v, 1'b0, 1'b0, 1'b1, rst));
    endtask

    initial begin
        // Reset held two cycles with a nonzero input.
        tick(4'd7, 1'b1);
        check("rst1_t", d_tens, 9'h100);
        check("rst1_u", d_units, 9'h100);
        tick(4'd7, 1'b1);
        check("rst2_t", d_tens, 9'h100);
        check("rst2_u", d_units, 9'h100);
        check("rst_al_t", a_tens, 9'h1FF);
        check("rst_al_u", a_units, 9'h1FF);
        check("rst_blank_t", b_tens, 9'h100);
        tick(4'd7, 1'b0);
        check("rel_t", d_tens, 9'h03F);
        check("rel_u", d_units, 9'h007);

        // Full sweep.
        for (int i = 0; i < 16; i++) begin
            tick(4'(i), 1'b0);
            check_model($sformatf("sweep%0d", i));
            case (i)
                0: begin
                    check("s0_t", d_tens, 9'h03F);   check("s0_u", d_units, 9'h03F);
                    check("al0_t", a_tens, 9'h0C0);  check("al0_u", a_units, 9'h0C0);
                end
                5:  begin check("bl5_t", b_tens, 9'h000);  check("bl5_u", b_units, 9'h06D); end
                9:  begin check("s9_t", d_tens, 9'h03F);   check("s9_u", d_units, 9'h06F); end
                10: begin check("s10_t", d_tens, 9'h006);  check("s10_u", d_units, 9'h03F); end
                11: begin check("bl11_t", b_tens, 9'h006); check("bl11_u", b_units, 9'h006); end
                12: begin check("s12_t", d_tens, 9'h006);  check("s12_u", d_units, 9'h05B); end
                15: begin check("s15_t", d_tens, 9'h006);  check("s15_u", d_units, 9'h06D); end
                default: ;
            endcase
        end

        // Wrap 15 -> 0.
        tick(4'd0, 1'b0);
        check("wrap_t", d_tens, 9'h03F);
        check("wrap_u", d_units, 9'h03F);

        // One-cycle reset in the middle of a sweep.
        tick(4'd12, 1'b0);
        check("mid12_u", d_units, 9'h05B);
        tick(4'd13, 1'b1);
        check("mid_rst_t", d_tens, 9'h100);
        check("mid_rst_u", d_units, 9'h100);
        check("mid_rst_al", a_units, 9'h1FF);
        tick(4'd14, 1'b0);
        check("mid14_t", d_tens, 9'h006);
        check("mid14_u", d_units, 9'h066);

        // Random values with occasional reset.
        for (int n = 0; n < 200; n++) begin
            tick(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
            check_model($sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
